// File: rtl/bus_grant_scheduler.sv
// Round-robin bus-ownership scheduler: one registered grant, held until the switch pulses xfer_done.
// Defining BUS_GRANT_TIMEOUT_EN adds a watchdog that revokes a grant held for MAX_HOLD cycles.
module bus_grant_scheduler #(
  parameter int  NREQ     = 5,
  parameter int  MAX_HOLD = 64,
  parameter int  CNT_W    = 7,
  localparam int IDX_W    = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             xfer_done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_id,
  output logic [NREQ-1:0]  grant_onehot,
  output logic             grant_start,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             grant_valid_d;
  logic [IDX_W-1:0] grant_id_d;
  logic [NREQ-1:0]  grant_onehot_d;
  logic             grant_start_d;
  logic [IDX_W:0]   pick;
  logic             expire;

  if (2 ** CNT_W <= MAX_HOLD) begin : g_cfg_check
    $error("CNT_W too narrow to count to MAX_HOLD");
  end

  // Returns {found, index} of the first set request at or after ptr, wrapping at NREQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0]  r,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] pos;
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(NREQ)) pos = pos - (IDX_W + 1)'(NREQ);
      if (r[pos[IDX_W-1:0]]) res = {1'b1, pos[IDX_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] id);
    return (id == IDX_W'(NREQ - 1)) ? '0 : id + IDX_W'(1);
  endfunction

  assign pick = rr_pick(req, rr_ptr_q);

`ifdef BUS_GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;
  logic             timeout_d;

  assign expire    = (state_q != S_IDLE) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  // xfer_done in the expiry cycle is a normal release, so no timeout pulse.
  assign timeout_d = expire && !xfer_done;
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (state_d == S_GRANT)     hold_cnt_q <= '0;
      else if (state_q != S_IDLE) hold_cnt_q <= hold_cnt_q + CNT_W'(1);
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would otherwise infer a latch.
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_valid_d  = grant_valid;
    grant_id_d     = grant_id;
    grant_onehot_d = grant_onehot;
    grant_start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick[IDX_W]) begin
          state_d                         = S_GRANT;
          grant_valid_d                   = 1'b1;
          grant_id_d                      = pick[IDX_W-1:0];
          grant_onehot_d                  = '0;
          grant_onehot_d[pick[IDX_W-1:0]] = 1'b1;
          grant_start_d                   = 1'b1;
        end
      end
      S_GRANT, S_HOLD: begin
        state_d = S_HOLD;
        if (xfer_done || expire) begin
          state_d        = S_IDLE;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
          rr_ptr_d       = wrap_inc(grant_id);
        end
      end
      default: begin
        state_d        = S_IDLE;
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      grant_start  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_valid  <= grant_valid_d;
      grant_id     <= grant_id_d;
      grant_onehot <= grant_onehot_d;
      grant_start  <= grant_start_d;
    end
  end

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Scoreboard bench for bus_grant_scheduler: directed scenarios plus random transactions against a round-robin model.
module tb_bus_grant_scheduler;
  localparam int NREQ        = 5;
  localparam int IDX_W       = $clog2(NREQ);
  localparam int TB_MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic             xfer_done;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_id;
  logic [NREQ-1:0]  grant_onehot;
  logic             grant_start;
  logic             timeout;

  int n_checks  = 0;
  int n_errors  = 0;
  int model_ptr = 0;
  int exp_q[$];

  bus_grant_scheduler #(
    .NREQ    (NREQ),
    .MAX_HOLD(TB_MAX_HOLD),
    .CNT_W   (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .xfer_done   (xfer_done),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_onehot(grant_onehot),
    .grant_start (grant_start),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: lowest distance from the pointer, modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      int idx = (model_ptr + i) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: every new grant must match the oldest expected winner.
  always @(negedge clk) begin
    if (!reset) begin
      check("onehot_form", 32'(grant_onehot),
            grant_valid ? (32'd1 << grant_id) : 32'd0);
      if (grant_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant_id), 32'hFFFF_FFFF);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("grant_id", 32'(grant_id), 32'(e));
          check("grant_onehot", 32'(grant_onehot), 32'd1 << e);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the release negedge (DUT idle again).
  task automatic do_grant(input logic [NREQ-1:0] r, input int k, input logic [NREQ-1:0] hold_req);
    int w;
    w = model_pick(r);
    exp_q.push_back(w);
    req = r;
    @(negedge clk);
    check("start_latency", 32'(grant_start), 32'd1);
    check("valid_latency", 32'(grant_valid), 32'd1);
    req = hold_req;
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(grant_valid), 32'd1);
      check("hold_start", 32'(grant_start), 32'd0);
      check("hold_id", 32'(grant_id), 32'(w));
    end
    xfer_done = 1'b1;
    @(negedge clk);
    xfer_done = 1'b0;
    check("release_valid", 32'(grant_valid), 32'd0);
    check("release_onehot", 32'(grant_onehot), 32'd0);
    check("release_timeout", 32'(timeout), 32'd0);
    check("release_id_kept", 32'(grant_id), 32'(w));
    model_ptr = (w + 1) % NREQ;
  endtask

  task automatic idle_cycles(input int n, input logic pulse);
    req       = '0;
    xfer_done = pulse;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      xfer_done = 1'b0;
      check("idle_valid", 32'(grant_valid), 32'd0);
      check("idle_start", 32'(grant_start), 32'd0);
    end
  endtask

`ifdef BUS_GRANT_TIMEOUT_EN
  task automatic do_timeout(input logic [NREQ-1:0] r, input logic xfer_at_expiry);
    int w;
    w = model_pick(r);
    exp_q.push_back(w);
    req = r;
    @(negedge clk);
    check("wd_start", 32'(grant_start), 32'd1);
    for (int c = 1; c < TB_MAX_HOLD; c++) begin
      @(negedge clk);
      check("wd_hold_valid", 32'(grant_valid), 32'd1);
      check("wd_hold_timeout", 32'(timeout), 32'd0);
    end
    xfer_done = xfer_at_expiry;
    @(negedge clk);
    xfer_done = 1'b0;
    check("wd_valid", 32'(grant_valid), 32'd0);
    check("wd_timeout", 32'(timeout), xfer_at_expiry ? 32'd0 : 32'd1);
    model_ptr = (w + 1) % NREQ;
    req = '0;
    @(negedge clk);
    check("wd_pulse_len", 32'(timeout), 32'd0);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    req       = '0;
    xfer_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_onehot", 32'(grant_onehot), 32'd0);
    check("rst_start", 32'(grant_start), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;

    // Single requester 4, then ignored xfer_done while idle.
    do_grant(5'b10000, 4, 5'b10000);
    idle_cycles(2, 1'b1);

    // Full contention: 0,1,2,3,4,0.
    for (int i = 0; i < 6; i++) do_grant(5'b11111, 3, 5'b11111);

    // Wrap from pointer 4.
    do_grant(5'b01000, 2, 5'b01000);
    do_grant(5'b00011, 1, 5'b00011);
    do_grant(5'b00011, 0, 5'b00011);

    // Owner drops and another requester rises mid-hold.
    do_grant(5'b00100, 4, 5'b01000);
    do_grant(5'b01000, 2, 5'b01000);

    // Reset during HOLD of D1 with the pointer parked at 2.
    do_grant(5'b00010, 1, 5'b00000);
    begin
      int w;
      w = model_pick(5'b00010);
      exp_q.push_back(w);
      req = 5'b00010;
      @(negedge clk);
      check("rst_pre_start", 32'(grant_start), 32'd1);
      @(negedge clk);
      check("rst_pre_hold", 32'(grant_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_valid", 32'(grant_valid), 32'd0);
      check("async_id", 32'(grant_id), 32'd0);
      check("async_onehot", 32'(grant_onehot), 32'd0);
      check("async_start", 32'(grant_start), 32'd0);
      model_ptr = 0;
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
    end
    do_grant(5'b00110, 2, 5'b00110);

`ifdef BUS_GRANT_TIMEOUT_EN
    do_timeout(5'b00100, 1'b0);
    do_grant(5'b00101, 1, 5'b00101);
    do_timeout(5'b00100, 1'b1);
`endif

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      do_grant(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 5)), NREQ'($urandom));
    end

    req = '0;
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
